sp_fifo_ctrl: RTL
=================

// Module: sp_fifo_ctrl
// PURPOSE
//   Valid/ready FIFO controller around one external single-port RAM (1 access/cycle,
//   read data registered, 1-cycle latency). Arbitrates push writes and pop prefetch
//   reads onto the shared port; 2-entry output buffer hides read latency.
//   Total capacity = 2^AW (RAM) + 2 (output buffer).
// PARAMETERS
//   DW  16  data width
//   AW  8   RAM address width; RAM depth D = 1<<AW
// PORTS
//   clk        in   1     clock, all logic on posedge
//   rst_n      in   1     synchronous, active-low reset
//   in_valid   in   1     push request
//   in_ready   out  1     push accepted when in_valid & in_ready
//   in_data    in   DW    push data
//   out_valid  out  1     head of FIFO valid
//   out_ready  in   1     pop when out_valid & out_ready
//   out_data   out  DW    head data (oldest entry)
//   level      out  AW+2  entries held: RAM + in-flight read + output buffer
//   ram_ce     out  1     RAM chip enable
//   ram_we     out  1     1 = write, 0 = read (when ram_ce)
//   ram_addr   out  AW    RAM address
//   ram_wdata  out  DW    RAM write data (= in_data)
//   ram_rdata  in   DW    RAM read data, valid cycle after read issue
// BEHAVIOUR
//   One clock clk; reset rst_n is synchronous and active-low.
//   State: wr_ptr, rd_ptr (AW+1 b, MSB = wrap bit), ram_cnt (AW+1 b), rd_pend (1 b),
//     obuf (2 entries, FIFO order), obuf_cnt (0..2), rr (last conflict winner).
//   Reset: ptrs/counts/rd_pend/rr = 0; out_valid = 0; level = 0; in_ready = 0,
//     ram_ce = 0 while rst_n low. Reset mid-operation discards all contents and any
//     pending read; RAM is not cleared.
//   pop  = out_valid & out_ready.
//   rd_req = (ram_cnt != 0) & (obuf_cnt + rd_pend - pop < 2).
//   wr_req = in_valid & (ram_cnt != D).
//   Arbitration (one port op/cycle): only one req -> it wins; both -> winner is the
//     one NOT granted at the previous conflict (rr toggles on each conflict only).
//     After reset first conflict goes to write.
//   in_ready = (ram_cnt != D) & !(rd_req & rr_prefers_read); independent of in_valid.
//   Write grant: ram_ce=1, ram_we=1, ram_addr=wr_ptr[AW-1:0]; wr_ptr++, ram_cnt++.
//   Read grant: ram_ce=1, ram_we=0, ram_addr=rd_ptr[AW-1:0]; rd_ptr++, ram_cnt--,
//     rd_pend<=1. Next cycle ram_rdata pushed into obuf at tail (rd_pend<=0 unless
//     re-issued). Push and pop of obuf in same cycle allowed.
//   out_valid = obuf_cnt != 0; out_data = obuf head; stable while out_valid & !out_ready.
//   Pointer wrap: address = ptr[AW-1:0]; modulo 2^(AW+1) increment, no special case.
//   Full: ram_cnt == D blocks writes (in_ready=0) even if obuf has space.
//   Empty: ram_cnt == 0 -> no reads; out_valid falls when obuf drains.
//   Latency: push accepted edge N -> RAM write N, read issued N+1 (if idle),
//     out_valid at N+3. No bypass path.
//   Throughput: push-only or pop-only 1/cycle; concurrent push+pop share port, 1/2 each.
//   level = ram_cnt + rd_pend + obuf_cnt, registered-state sum, max D+2.
// TESTING
//   1 Reset: hold rst_n=0 3 cycles with in_valid=1 -> in_ready=0, ram_ce=0, out_valid=0,
//     level=0.
//   2 Single push 0x1234 into empty, out_ready=1 -> ram write @addr 0, read @addr 0 next
//     cycle, out_valid=1 with 0x1234 exactly 3 cycles after handshake, level back to 0.
//   3 Fill with out_ready=0, AW=2: push 0..9 -> in_ready drops after 6 accepts (4 RAM +
//     2 obuf), level=6; pop all -> order 0..5, ptr wrap exercised on second fill.
//   4 Continuous in_valid=1 and out_ready=1 from half-full -> ram_we alternates 1/0 each
//     cycle (rr), no data loss/reorder over 1000 random values vs. reference queue model.
//   5 Backpressure: random out_ready 30% -> out_data stable while stalled, obuf never
//     >2, level matches model every cycle.
//   6 Reset mid-stream (level=5, rd_pend=1) -> next cycle level=0, out_valid=0; subsequent
//     push 0xBEEF emerges first.

Source files
------------

// File: rtl/sp_fifo_ctrl.sv
// Valid/ready FIFO controller driving one external single-port RAM (1-cycle read latency).
// Write pushes and prefetch reads share the port; a 2-entry output buffer hides read latency.
module sp_fifo_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] level,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = AW + 2;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rr_q, rr_d;
  logic [DW-1:0] obuf0_q, obuf0_d;
  logic [DW-1:0] obuf1_q, obuf1_d;
  logic [1:0]    obuf_cnt_q, obuf_cnt_d;

  logic       pop;
  logic       ram_empty;
  logic       ram_full;
  logic [1:0] obuf_occ;
  logic       rd_req;
  logic       wr_req;
  logic       wr_gnt;
  logic       rd_gnt;

  // Wrap-bit pointer compare decides full/empty; ram_cnt only feeds level.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop      = out_valid & out_ready;
  assign obuf_occ = obuf_cnt_q + 2'(rd_pend_q) - 2'(pop);
  assign rd_req   = !ram_empty && (obuf_occ < 2'd2);
  assign wr_req   = in_valid & !ram_full;

  // rr_q set means the last conflict went to the write, so the read is preferred next.
  assign wr_gnt = rst_n & wr_req & (!rd_req | !rr_q);
  assign rd_gnt = rst_n & rd_req & (!wr_req | rr_q);

  assign in_ready  = rst_n & !ram_full & !(rd_req & rr_q);
  assign ram_ce    = wr_gnt | rd_gnt;
  assign ram_we    = wr_gnt;
  assign ram_addr  = wr_gnt ? wr_ptr_q[AW-1:0] : rd_ptr_q[AW-1:0];
  assign ram_wdata = in_data;

  assign out_valid = (obuf_cnt_q != 2'd0);
  assign out_data  = obuf0_q;
  assign level     = LW'(ram_cnt_q) + LW'(rd_pend_q) + LW'(obuf_cnt_q);

  // Next-state: port grant bookkeeping and output-buffer push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    rd_pend_d  = rd_gnt;
    rr_d       = rr_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;

    if (wr_req && rd_req) begin
      rr_d = ~rr_q;
    end

    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      ram_cnt_d = ram_cnt_q + PW'(1);
    end else if (rd_gnt) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      ram_cnt_d = ram_cnt_q - PW'(1);
    end

    case ({rd_pend_q, pop})
      2'b01: begin
        obuf0_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q - 2'd1;
      end
      2'b10: begin
        if (obuf_cnt_q == 2'd0) obuf0_d = ram_rdata;
        else                    obuf1_d = ram_rdata;
        obuf_cnt_d = obuf_cnt_q + 2'd1;
      end
      2'b11: begin
        if (obuf_cnt_q == 2'd1) begin
          obuf0_d = ram_rdata;
        end else begin
          obuf0_d = obuf1_q;
          obuf1_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      rr_q       <= 1'b0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      obuf_cnt_q <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rr_q       <= rr_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end

endmodule
